// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a registered serial bit
// and hands them out through a valid/ready output register. The shift register and the
// output register are separate. A word that completes while the output register is still
// occupied is dropped, and the sticky overrun flag is set.
module serial_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_valid,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun
);

    localparam int unsigned       CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_shift_ins;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_next;
    logic               w_complete;
    logic [WIDTH-1:0]   r_out_data;
    logic [WIDTH-1:0]   w_out_data_next;
    logic               r_out_valid;
    logic               w_out_valid_next;
    logic               r_overrun;
    logic               w_overrun_next;

    // Shift register with the new bit inserted at the end selected by MSB_FIRST.
    always_comb begin
        if (MSB_FIRST) begin
            w_shift_ins = {r_shift[WIDTH-2:0], din};
        end else begin
            w_shift_ins = {din, r_shift[WIDTH-1:1]};
        end
    end

    // Capture FSM next state. flush wins over any bit that is sampled on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_count_next = r_count;
        w_complete   = 1'b0;
        if (flush) begin
            w_state_next = StIdle;
            w_shift_next = '0;
            w_count_next = '0;
        end else if (din_valid) begin
            unique case (r_state)
                StIdle: begin
                    w_shift_next = w_shift_ins;
                    w_count_next = CW'(1);
                    w_state_next = StShift;
                end
                StShift: begin
                    w_shift_next = w_shift_ins;
                    if (r_count == LAST_CNT) begin
                        w_complete   = 1'b1;
                        w_count_next = '0;
                        w_state_next = StIdle;
                    end else begin
                        w_count_next = r_count + CW'(1);
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // Output register. A completed word loads when the slot is free or is drained on this
    // same edge; otherwise the word is dropped and overrun is flagged.
    always_comb begin
        w_out_data_next  = r_out_data;
        w_out_valid_next = r_out_valid;
        w_overrun_next   = r_overrun;
        if (w_complete) begin
            if (!r_out_valid || out_ready) begin
                w_out_data_next  = w_shift_ins;
                w_out_valid_next = 1'b1;
            end else begin
                w_overrun_next = 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            w_out_valid_next = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_count     <= w_count_next;
            r_out_data  <= w_out_data_next;
            r_out_valid <= w_out_valid_next;
            r_overrun   <= w_overrun_next;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == StShift);
    assign bit_count = r_count;
    assign overrun   = r_overrun;

endmodule
